ping_pong_stream_reader: RTL and testbench
==========================================

# ping_pong_stream_reader

Drain-side controller for the ping-pong buffer read port. It pulls completed buffers word by word through the buffer's read_en/read_data/read_empty interface and absorbs the buffer's one-cycle registered read latency with a small credit-managed output FIFO. It re-emits each buffer as one framed valid/ready stream packet, with the last-word marker and a buffer tag, to downstream consumers such as DMA or packetizer logic.

## Interface
- DATA_WIDTH, 8, word width; must match the ping-pong buffer.
- BUFFER_SIZE, 16, words per buffer (frame length); power of two, at least 2.
- FIFO_DEPTH, 2, output FIFO entries; at least 2.

Ports:
- clk  in  1  clock; one clock domain only.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  permits starting a new frame; sampled only in IDLE.
- pp_read_en  out  1  read strobe to the buffer; combinational.
- pp_read_data  in  DATA_WIDTH  buffer read data; valid the cycle after an accepted pp_read_en.
- pp_read_empty  in  1  buffer has no readable word.
- pp_current_read_buffer  in  1  buffer's active read bank.
- m_valid  out  1  output word valid.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  final word of the frame.
- m_buf_id  out  1  bank (0 or 1) the frame came from.
- m_ready  in  1  downstream accept.
- busy  out  1  frame in progress, read in flight, or FIFO non-empty.

## Operation
- FSM has two states.
  - IDLE: no frame open.
  - ACTIVE: frame open; word index idx runs 0..BUFFER_SIZE-1, width $clog2(BUFFER_SIZE).
- Issue condition: issue = !pp_read_empty && credit_ok && (state==ACTIVE || enable).
  - pp_read_en = issue.
  - credit_ok = occ + inflight - pop < FIFO_DEPTH, where pop = m_valid && m_ready.
- IDLE with issue:
  - Word 0 is issued.
  - pp_current_read_buffer is captured into the frame tag.
  - idx becomes 1 and the FSM goes to ACTIVE.
- ACTIVE with issue: idx increments.
  - Issuing idx == BUFFER_SIZE-1 marks the word last, clears idx to 0 and returns the FSM to IDLE.
- Stalls:
  - pp_read_empty high in ACTIVE (mid-frame) stalls issue; no error, no state change.
  - Deasserting enable mid-frame does not abort; the frame completes and no new frame starts.
- Each issued read sets a one-deep in-flight register carrying {last, tag}.
  - On the next edge, pp_read_data plus {last, tag} are pushed into the FIFO.
- The FIFO head drives m_data, m_last and m_buf_id; m_valid = (occ != 0).
- Push and pop in the same cycle are allowed; occupancy stays constant.
- A m_valid beat must remain stable until accepted (AXI-style).
- Reset values: pp_read_en 0, m_valid 0, m_data 0, m_last 0, m_buf_id 0, busy 0.
  - Also reset: FSM IDLE, idx 0, occ 0, inflight 0.
- Reset mid-frame discards all FIFO and in-flight words. The remaining words of that frame stay in the buffer and are not this block's concern.

## Timing
- Latency: pp_read_en high in cycle t, then pp_read_data is valid in t+1, then m_valid is high in t+2 (FIFO empty, no stall).
- Throughput: one word per cycle with m_ready held high and FIFO_DEPTH of at least 2.
- No bubble between consecutive frames when the next bank is ready. The IDLE-to-word-0 issue happens in the cycle following the last-word issue.
- The credit rule guarantees FIFO overflow never occurs; pushing into a full FIFO is impossible by construction.
- The word counter wraps only through the explicit last-word clear, never by overflow.

## Configuration
- Macro: PING_PONG_STREAM_READER_STATS_EN.
- Defined: two extra outputs, each a saturating 16-bit counter reset to 0.
  - frame_count counts +1 per accepted beat with m_last set.
  - stall_cycles counts +1 per cycle with m_valid && !m_ready.
  - Both saturate at 16'hFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs immediately at reset values; busy 0; no pp_read_en until rst is low and pp_read_empty is low.
- Single frame: BUFFER_SIZE=16, bank 0 filled with 0x00..0x0F, m_ready=1, enable=1 -> 16 contiguous beats 0x00..0x0F; m_last only on 0x0F; m_buf_id=0; first m_valid 2 cycles after first pp_read_en.
- Back-to-back: both banks pre-filled, bank 0 with 0x00..0x0F and bank 1 with 0x10..0x1F -> 32 contiguous beats; m_buf_id 0 then 1; m_last on 0x0F and on 0x1F; no idle cycle between frames.
- Backpressure: m_ready random at 30% high -> data sequence intact; beats stable while stalled; occ + inflight never exceeds FIFO_DEPTH; no pp_read_en while credit is 0.
- Enable drop: enable low after word 5 of a frame with the other bank ready -> words 6..15 still delivered; no further pp_read_en; busy falls 0 after the last beat is accepted.
- Stats (macro on): 3 frames with 10 injected stall cycles -> frame_count=3, stall_cycles=10; force 70000 stall cycles -> stall_cycles=0xFFFF.

Source files
------------

// File: rtl/ping_pong_stream_reader.sv
// Drains completed ping-pong buffer banks into framed valid/ready packets with last and bank tag.
// Optional PING_PONG_STREAM_READER_STATS_EN adds saturating frame_count and stall_cycles outputs.
module ping_pong_stream_reader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BUFFER_SIZE = 16,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  pp_read_en,
    input  logic [DATA_WIDTH-1:0] pp_read_data,
    input  logic                  pp_read_empty,
    input  logic                  pp_current_read_buffer,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_buf_id,
    input  logic                  m_ready,
`ifdef PING_PONG_STREAM_READER_STATS_EN
    output logic [15:0]           frame_count,
    output logic [15:0]           stall_cycles,
`endif
    output logic                  busy
);

    localparam int unsigned IW = $clog2(BUFFER_SIZE);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW = DATA_WIDTH + 2;

    typedef enum logic {StIdle, StActive} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          tag_q, tag_d;

    logic          inflight_q;
    logic          inflight_last_q;
    logic          inflight_tag_q;

    logic [EW-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [OW-1:0] occ_q;

    logic          issue;
    logic          issue_last;
    logic          issue_tag;
    logic          pop;
    logic          push;
    logic          credit_ok;
    logic [OW:0]   committed;
    logic [EW-1:0] head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head    = fifo_q[rd_ptr_q];
    assign m_valid = (occ_q != '0);
    assign m_data  = head[DATA_WIDTH-1:0];
    assign m_last  = head[DATA_WIDTH];
    assign m_buf_id = head[DATA_WIDTH+1];
    assign pop     = m_valid && m_ready;
    assign push    = inflight_q;
    assign busy    = (state_q == StActive) || inflight_q || m_valid;

    // Words already owed to the FIFO (stored or in flight) after this cycle's pop.
    assign committed = {1'b0, occ_q} + (OW+1)'(inflight_q) - (OW+1)'(pop);
    assign credit_ok = committed < (OW+1)'(FIFO_DEPTH);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        issue_last = 1'b0;
        issue_tag  = tag_q;
        // Reset gates the strobe so nothing is read while the block is held.
        issue      = !rst && !pp_read_empty && credit_ok && ((state_q == StActive) || enable);
        if (issue) begin
            unique case (state_q)
                StIdle: begin
                    tag_d     = pp_current_read_buffer;
                    issue_tag = pp_current_read_buffer;
                    idx_d     = IW'(1);
                    state_d   = StActive;
                end
                StActive: begin
                    if (idx_q == IW'(BUFFER_SIZE - 1)) begin
                        issue_last = 1'b1;
                        idx_d      = '0;
                        state_d    = StIdle;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign pp_read_en = issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            inflight_tag_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_last_q <= issue_last;
                inflight_tag_q  <= issue_tag;
            end
        end
    end

    // Storage is cleared on reset so the idle head presents zeros downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {inflight_tag_q, inflight_last_q, pp_read_data};
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            occ_q <= occ_q + OW'(push) - OW'(pop);
        end
    end

`ifdef PING_PONG_STREAM_READER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (pop && m_last && (frame_count != 16'hFFFF)) begin
                frame_count <= frame_count + 16'd1;
            end
            if (m_valid && !m_ready && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ping_pong_stream_reader.sv
// Scoreboard bench for ping_pong_stream_reader with a behavioural two-bank buffer model.
module tb_ping_pong_stream_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned BS = 16;
    localparam int unsigned FD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          pp_read_en;
    logic [DW-1:0] pp_read_data;
    logic          pp_read_empty;
    logic          pp_current_read_buffer;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_buf_id;
    logic          m_ready;
    logic          busy;
`ifdef PING_PONG_STREAM_READER_STATS_EN
    logic [15:0]   frame_count;
    logic [15:0]   stall_cycles;
`endif

    ping_pong_stream_reader #(
        .DATA_WIDTH (DW),
        .BUFFER_SIZE(BS),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable                (enable),
        .pp_read_en            (pp_read_en),
        .pp_read_data          (pp_read_data),
        .pp_read_empty         (pp_read_empty),
        .pp_current_read_buffer(pp_current_read_buffer),
        .m_valid               (m_valid),
        .m_data                (m_data),
        .m_last                (m_last),
        .m_buf_id              (m_buf_id),
        .m_ready               (m_ready),
`ifdef PING_PONG_STREAM_READER_STATS_EN
        .frame_count           (frame_count),
        .stall_cycles          (stall_cycles),
`endif
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Buffer model: a bank is full while its fill generation leads its read generation.
    logic [DW-1:0] mem [2][BS];
    int            fill_gen [2] = '{0, 0};
    int            read_gen [2] = '{0, 0};
    logic          cur;
    logic [3:0]    rptr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur          <= 1'b0;
            rptr         <= '0;
            pp_read_data <= '0;
            read_gen[0]  <= fill_gen[0];
            read_gen[1]  <= fill_gen[1];
        end else if (pp_read_en) begin
            pp_read_data <= mem[cur][rptr];
            rptr         <= rptr + 4'd1;
            if (rptr == 4'(BS - 1)) begin
                read_gen[cur] <= read_gen[cur] + 1;
                cur           <= ~cur;
            end
        end
    end

    assign pp_read_empty          = (fill_gen[cur] == read_gen[cur]);
    assign pp_current_read_buffer = cur;

    logic [9:0] exp_q [$];
    int         cyc = 0;
    int         issued = 0;
    int         pops = 0;
    int         lost = 0;
    int         en_cyc [int];
    int         pop_cyc [int];
    logic       prev_stall = 1'b0;
    logic [9:0] prev_word;

    always @(negedge clk) begin
        logic [9:0] e;
        cyc++;
        if (rst) begin
            lost       = issued - pops;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 32'(m_valid), 1);
                check_eq("stall_stable", 32'({m_buf_id, m_last, m_data}), 32'(prev_word));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_nonempty", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("data", 32'(m_data), 32'(e[7:0]));
                    check_eq("last", 32'(m_last), 32'(e[8]));
                    check_eq("buf_id", 32'(m_buf_id), 32'(e[9]));
                end
                pop_cyc[pops] = cyc;
                pops++;
            end
            if (pp_read_en) begin
                en_cyc[issued] = cyc;
                issued++;
                check_eq("credit", 32'((issued - pops - lost) <= int'(FD)), 1);
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_buf_id, m_last, m_data};
        end
    end

    task automatic push_exp(input int b, input int base);
        for (int i = 0; i < int'(BS); i++) begin
            exp_q.push_back({b[0], (i == int'(BS) - 1), 8'(base + i)});
        end
    endtask

    task automatic fill_bank(input int b, input int base, input bit push);
        int n = 0;
        while (fill_gen[b] != read_gen[b] && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) check_eq("fill_timeout", 32'(n), 0);
        for (int i = 0; i < int'(BS); i++) mem[b][i] = 8'(base + i);
        if (push) push_exp(b, base);
        fill_gen[b] = fill_gen[b] + 1;
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (pops < target) check_eq("pop_timeout", 32'(pops), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"}, 32'(pp_read_en), 0);
        check_eq({tag, "_valid"}, 32'(m_valid), 0);
        check_eq({tag, "_data"}, 32'(m_data), 0);
        check_eq({tag, "_last"}, 32'(m_last), 0);
        check_eq({tag, "_bufid"}, 32'(m_buf_id), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int e0;
        int p0;
        int n;
        rst     = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_no_en", 32'(pp_read_en), 0);

        // Single frame from bank 0: latency and contiguity.
        m_ready = 1'b1;
        fill_bank(0, 8'h00, 1);
        e0 = issued;
        p0 = pops;
        enable = 1'b1;
        wait_pops(p0 + 16, 200);
        check_eq("latency", 32'(pop_cyc[p0] - en_cyc[e0]), 2);
        check_eq("single_span", 32'(pop_cyc[p0 + 15] - pop_cyc[p0]), 15);

        // Asynchronous reset mid-frame on bank 1.
        fill_bank(1, 8'h40, 1);
        wait_pops(p0 + 20, 200);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back frames, bank 0 then bank 1, no gap.
        fill_bank(0, 8'h00, 1);
        fill_bank(1, 8'h10, 1);
        p0 = pops;
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_pops(p0 + 32, 300);
        check_eq("b2b_span", 32'(pop_cyc[p0 + 31] - pop_cyc[p0]), 31);

        // Random backpressure, ready high about 30% of cycles.
        fill_bank(0, 8'h80, 1);
        fill_bank(1, 8'hA0, 1);
        p0 = pops;
        n = 0;
        while (pops < p0 + 32 && n < 3000) begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(0, 9) < 3);
            n++;
        end
        check_eq("bp_done", 32'(pops - p0), 32);
        m_ready = 1'b1;

        // Enable dropped mid-frame with the other bank ready.
        enable = 1'b0;
        fill_bank(0, 8'h30, 1);
        fill_bank(1, 8'h50, 0);
        e0 = issued;
        p0 = pops;
        @(posedge clk);
        #1;
        enable = 1'b1;
        n = 0;
        while (issued < e0 + 6 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        enable = 1'b0;
        wait_pops(p0 + 16, 200);
        repeat (5) @(posedge clk);
        #1;
        check_eq("drop_issued", 32'(issued - e0), 16);
        check_eq("drop_busy", 32'(busy), 0);
        push_exp(1, 8'h50);
        enable = 1'b1;
        wait_pops(p0 + 32, 200);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(exp_q.size()), 0);

`ifdef PING_PONG_STREAM_READER_STATS_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b0;
        fill_bank(0, 8'h00, 1);
        fill_bank(1, 8'h10, 1);
        p0 = pops;
        enable = 1'b1;
        n = 0;
        while (!m_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        m_ready = 1'b1;
        fill_bank(0, 8'h20, 1);
        wait_pops(p0 + 48, 300);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("frame_count", 32'(frame_count), 3);
        check_eq("stall_cycles", 32'(stall_cycles), 10);
        m_ready = 1'b0;
        fill_bank(1, 8'h60, 1);
        enable = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        check_eq("stall_sat", 32'(stall_cycles), 32'hFFFF);
        check_eq("frame_hold", 32'(frame_count), 3);
        enable = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
